// File: rtl/br_wb_arbiter.sv
// rtl/br_wb_arbiter.sv - round-robin write-back arbiter and pending-write scoreboard for the register bank
// Optional `BR_WB_BYPASS_EN adds bypass hit/data outputs for the two hazard query ports.
module br_wb_arbiter #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          v0,
   input  logic [AW-1:0] a0,
   input  logic [DW-1:0] d0,
   input  logic          v1,
   input  logic [AW-1:0] a1,
   input  logic [DW-1:0] d1,
   output logic          r0,
   output logic          r1,
   input  logic          hold,
   input  logic          rsv_v,
   input  logic [AW-1:0] rsv_a,
   input  logic [AW-1:0] q1_a,
   input  logic [AW-1:0] q2_a,
   output logic          q1_p,
   output logic          q2_p,
   output logic          WE,
   output logic [AW-1:0] DE,
   output logic [DW-1:0] Dato,
   output logic [31:0]   pend
`ifdef BR_WB_BYPASS_EN
   ,
   output logic          b1_hit,
   output logic          b2_hit,
   output logic [DW-1:0] b1_d,
   output logic [DW-1:0] b2_d
`endif
);

   logic          r_prio;
   logic          r_we;
   logic [AW-1:0] r_de;
   logic [DW-1:0] r_dato;
   logic [31:0]   r_pend;

   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_xfer;
   logic [AW-1:0] w_sel_a;
   logic [DW-1:0] w_sel_d;
   logic [31:0]   w_pend_nxt;
   logic          w_b1_hit;
   logic          w_b2_hit;

   // A contested cycle goes to the channel named by r_prio; an uncontested one to whoever asks.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!hold && !rst) begin
         w_gnt0 = v0 && (!v1 || !r_prio);
         w_gnt1 = v1 && (!v0 ||  r_prio);
      end
   end

   assign w_xfer  = w_gnt0 || w_gnt1;
   assign w_sel_a = w_gnt1 ? a1 : a0;
   assign w_sel_d = w_gnt1 ? d1 : d0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prio <= 1'b0;
         r_we   <= 1'b0;
         r_de   <= '0;
         r_dato <= '0;
      end else begin
         if (w_xfer) begin
            r_prio <= w_gnt0;
         end
         // Register 0 is hardwired: its transfers are consumed but never reach the bank.
         r_we <= w_xfer && (w_sel_a != '0);
         if (w_xfer && (w_sel_a != '0)) begin
            r_de   <= w_sel_a;
            r_dato <= w_sel_d;
         end
      end
   end

   // Clear follows the bank write; a reservation in the same cycle is a newer producer and wins.
   always_comb begin
      w_pend_nxt = r_pend;
      if (r_we) begin
         w_pend_nxt[r_de] = 1'b0;
      end
      if (rsv_v && (rsv_a != '0)) begin
         w_pend_nxt[rsv_a] = 1'b1;
      end
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end

`ifdef BR_WB_BYPASS_EN
   assign w_b1_hit = r_we && (r_de != '0) && (r_de == q1_a);
   assign w_b2_hit = r_we && (r_de != '0) && (r_de == q2_a);
   assign b1_hit   = w_b1_hit;
   assign b2_hit   = w_b2_hit;
   assign b1_d     = r_dato;
   assign b2_d     = r_dato;
`else
   assign w_b1_hit = 1'b0;
   assign w_b2_hit = 1'b0;
`endif

   assign q1_p = !rst && (q1_a != '0) && r_pend[q1_a] && !w_b1_hit;
   assign q2_p = !rst && (q2_a != '0) && r_pend[q2_a] && !w_b2_hit;

   assign r0   = w_gnt0;
   assign r1   = w_gnt1;
   assign WE   = r_we;
   assign DE   = r_de;
   assign Dato = r_dato;
   assign pend = r_pend;

endmodule
